// File: rtl/bit_io_port.sv
// bit_io_port: addressed 1-bit I/O responder for the 1-bit processor.
// Region 0 (addr MSB = 0): write drives an output latch, read returns the
// synchronized input level. Region 1: sticky rising-edge flags, cleared by a
// read or by writing 0; a simultaneous rise always wins over a clear.
module bit_io_port #(
  parameter int A       = 3,
  parameter bit RST_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A-1:0]     addr,
  input  logic             write,
  input  logic             read,
  input  logic             result,
  output logic             data,
  input  logic [2**(A-1)-1:0] pins_in,
  output logic [2**(A-1)-1:0] pins_out
);

  localparam int N = 2**(A-1);

  logic [N-1:0] s1, s2, s3;
  logic [N-1:0] flags;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [1:0]   arm_cnt;
  logic         armed;
  logic         region;
  logic [A-2:0] ch;

  assign region = addr[A-1];
  assign ch     = addr[A-2:0];
  assign armed  = (arm_cnt == 2'd3);
  assign rise   = s2 & ~s3 & {N{armed}};

  // Two-stage input synchronizer plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= pins_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Arm counter: edge detection stays off until the sync pipeline has filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // Clear request for the addressed flag: a flag-region read, or writing 0.
  always_comb begin
    clr = '0;
    if (region && (read || (write && !result))) begin
      clr[ch] = 1'b1;
    end
  end

  // Sticky flags; the set term is OR-ed last so a rise beats a same-edge clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~clr) | rise;
    end
  end

  // Output latches, written only in the level region.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pins_out <= {N{RST_OUT}};
    end else if (write && !region) begin
      pins_out[ch] <= result;
    end
  end

  // Read data comes from registered state only: input level or flag.
  always_comb begin
    data = 1'b0;
    if (region) begin
      data = flags[ch];
    end else begin
      data = s2[ch];
    end
  end

endmodule

// File: tb/tb_bit_io_port.sv
// Self-checking bench for bit_io_port: directed scenarios followed by random
// traffic, all compared against a sample-history reference model.
module tb_bit_io_port;

  localparam int A  = 3;
  localparam int N  = 4;
  localparam bit RO = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [A-1:0] addr = '0;
  logic         write = 1'b0;
  logic         read = 1'b0;
  logic         result = 1'b0;
  logic         data;
  logic [N-1:0] pins_in = '0;
  logic [N-1:0] pins_out;

  int checks = 0;
  int failures = 0;

  // Reference model: recent pin samples (newest last), edges since reset,
  // flag bits and output latches.
  logic [N-1:0] hist[$];
  int           edges;
  logic [N-1:0] flags_m;
  logic [N-1:0] out_m;

  always #5 clk = ~clk;

  bit_io_port #(.A(A), .RST_OUT(RO)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .write(write),
    .read(read),
    .result(result),
    .data(data),
    .pins_in(pins_in),
    .pins_out(pins_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pin value sampled 'back' edges before the newest sample; 0 before reset.
  function automatic logic [N-1:0] samp(input int back);
    if (hist.size() > back) return hist[hist.size()-1-back];
    return '0;
  endfunction

  function automatic logic exp_data();
    logic [N-1:0] v;
    int c;
    c = int'(addr[A-2:0]);
    if (addr[A-1]) v = flags_m;
    else v = samp(1);
    return v[c];
  endfunction

  task automatic model_reset();
    hist.delete();
    edges = 0;
    flags_m = '0;
    out_m = {N{RO}};
  endtask

  task automatic model_edge();
    logic [N-1:0] rise_m;
    logic [N-1:0] clr_m;
    int c;
    c = int'(addr[A-2:0]);
    // A flag may set only once three edges have passed since reset release.
    rise_m = samp(1) & ~samp(2) & {N{edges >= 3}};
    clr_m = '0;
    if (addr[A-1] && (read || (write && !result))) clr_m[c] = 1'b1;
    if (write && !addr[A-1]) out_m[c] = result;
    flags_m = (flags_m & ~clr_m) | rise_m;
    hist.push_back(pins_in);
    if (hist.size() > 3) void'(hist.pop_front());
    if (edges < 3) edges++;
  endtask

  task automatic tick();
    #1 check("data_pre", {31'd0, data}, {31'd0, exp_data()});
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check("data", {31'd0, data}, {31'd0, exp_data()});
    check("pins_out", {28'd0, pins_out}, {28'd0, out_m});
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    model_reset();
    #1 check("rst_pins_out", {28'd0, pins_out}, 32'hF);
  endtask

  initial begin
    model_reset();

    // Reset state
    tick();
    tick();
    check("rst_out_const", {28'd0, pins_out}, 32'hF);
    addr = 3'b100;
    tick();
    check("rst_flag0", {31'd0, data}, 32'd0);
    rst = 1'b1;
    repeat (4) tick();

    // Write latency on pin 2
    addr = 3'b010; write = 1'b1; result = 1'b0;
    tick();
    check("wr_clr_pin2", {28'd0, pins_out}, 32'hB);
    result = 1'b1;
    tick();
    check("wr_set_pin2", {28'd0, pins_out}, 32'hF);
    write = 1'b0;

    // Synchronizer and edge flag on pin 1
    addr = 3'b001; pins_in = 4'b0010;
    tick();
    check("lvl_1clk", {31'd0, data}, 32'd0);
    tick();
    check("lvl_2clk", {31'd0, data}, 32'd1);
    addr = 3'b101;
    #1 check("flag_2clk", {31'd0, data}, 32'd0);
    tick();
    check("flag_3clk", {31'd0, data}, 32'd1);

    // Read-to-clear
    read = 1'b1;
    #1 check("rtc_same", {31'd0, data}, 32'd1);
    tick();
    check("rtc_next", {31'd0, data}, 32'd0);
    read = 1'b0;

    // Write 0 clears
    pins_in = 4'b0000; repeat (3) tick();
    pins_in = 4'b0010; repeat (3) tick();
    check("flag1_again", {31'd0, data}, 32'd1);
    write = 1'b1; result = 1'b0;
    tick();
    write = 1'b0;
    check("wr0_clears", {31'd0, data}, 32'd0);

    // Write 1 is ignored in flag region
    pins_in = 4'b0000; repeat (3) tick();
    pins_in = 4'b0010; repeat (3) tick();
    write = 1'b1; result = 1'b1;
    tick();
    write = 1'b0;
    check("wr1_ignored", {31'd0, data}, 32'd1);

    // Rise on pin 2 coincides with a clearing read
    addr = 3'b110; pins_in = 4'b0110;
    tick();
    tick();
    read = 1'b1;
    tick();
    read = 1'b0;
    check("collision", {31'd0, data}, 32'd1);

    // Pins high across reset release never set a flag
    pins_in = 4'hF;
    enter_reset();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    for (int c = 0; c < N; c++) begin
      addr = 3'(4 + c);
      #1 check("no_flag_armup", {31'd0, data}, 32'd0);
    end
    pins_in[0] = 1'b0;
    addr = 3'b100;
    repeat (5) tick();
    pins_in[0] = 1'b1;
    repeat (3) tick();
    check("arm_flag0", {31'd0, data}, 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      addr = A'($urandom);
      write = ($urandom_range(3) == 0);
      read = ($urandom_range(3) == 0);
      result = 1'($urandom);
      if ($urandom_range(2) == 0) pins_in = N'($urandom);
      if ($urandom_range(99) == 0) enter_reset();
      else if (!rst) rst = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_io_port.md
Name: bit_io_port

Overview:
- Addressed 1-bit I/O responder for the 1-bit processor.
- Consumes the processor's write strobe and result bit, and returns the data bit the processor samples.
- Provides N registered output pins, N synchronized input pins, and per-channel sticky rising-edge flags with read-to-clear.
- Sits beside the processor top on the same clk/rst domain; addr is driven from the instruction operand field.

Parameters:
- A, 3, address width; channel count N = 2**(A-1) (default 4).
- RST_OUT, 0, reset value replicated onto every pins_out bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  A  addr[A-1] selects region (0 = level/latch, 1 = flag); addr[A-2:0] selects channel.
- write  input  1  write strobe from processor, sampled on clk rise.
- read  input  1  read strobe; in flag region, clears the addressed flag.
- result  input  1  bit to be written.
- data  output  1  bit returned to processor; combinational from registered state only.
- pins_in  input  N  asynchronous external inputs.
- pins_out  output  N  registered output latches.

Behaviour:
- Reset (rst low, async):
  - pins_out = {N{RST_OUT}}; sync stages s1, s2 and history s3 = 0; flags = 0; arm counter = 0; armed = 0.
- Input synchronizer:
  - Per channel, s1 <= pins_in, s2 <= s1, s3 <= s2.
  - Level value = s2, so pins_in reaches the level path in 2 clocks.
- Arm counter:
  - 2-bit counter increments each clock after reset until it reaches 3, then holds; armed = (count == 3).
  - While not armed, edge detection is suppressed, so a pin held high through reset never sets a flag.
- Rise detect: rise[ch] = s2 & ~s3 & armed. Flag sets on the clock edge after rise is true.
- Write, level region (addr[A-1] = 0, write = 1):
  - pins_out[ch] <= result at the clock edge; visible the following cycle (1-cycle latency).
- Write, flag region (addr[A-1] = 1, write = 1):
  - result = 0 clears flag[ch]; result = 1 is ignored (software cannot set a flag).
- Read, flag region (read = 1, addr[A-1] = 1):
  - data shows the current flag in the same cycle; flag[ch] clears at that edge.
- Read, level region: no side effect.
- Priority: a rise on the same edge as a clear (by read or write) leaves the flag set.
- data mux:
  - addr[A-1] = 0 -> s2[ch]. Input level, not the output latch; output latches are not readable, and software tracks them.
  - addr[A-1] = 1 -> flag[ch].
- write and read asserted together on the same address: the write action and the read action both apply; flag set priority still holds.
- Unused strobes: write and read outside any action have no effect; any addr value is legal, so there is no error path.
- Mid-operation reset: everything returns to reset values immediately; the arm sequence restarts on rst release.
- Pin glitches: pulses shorter than one clock may be missed. No debounce; that is out of scope.

Test Plan:
- Reset value: RST_OUT = 1, pulse rst low mid-run -> pins_out = 4'b1111 immediately; flags 0; data = 0 at addr 3'b100.
- Write latency: write = 1, addr = 3'b010, result = 1 for one cycle -> pins_out[2] = 1 from the next cycle; other bits unchanged.
- Sync and edge: pins_in[1] 0 -> 1 (armed) -> data at addr 3'b001 = 1 after 2 clocks; data at addr 3'b101 = 1 after 3 clocks.
- Read-to-clear: with flag[1] = 1, read = 1 at addr 3'b101 -> data = 1 that cycle, 0 the next. Repeat with write = 1, result = 0 -> cleared. Repeat with result = 1 -> flag unchanged.
- Set/clear collision: time read = 1 on addr 3'b110 to coincide with a new rise on pins_in[2] -> flag[2] remains 1.
- Arm suppression: pins_in = 4'b1111 held across rst release -> no flag set ever; then drop pin 0 and raise it after 5 clocks -> flag[0] = 1.
